// File: rtl/thread_scheduler.sv
// ---------------------------------------------------------------------------
// thread_scheduler
//
// Round-robin fetch scheduler for a 5-context barrel pipeline. Each cycle it
// picks the thread whose PC is read for fetch, decides whether that PC is
// advanced (PC+4) or overwritten by a resolved branch target, and tags the
// instruction returned one cycle later with the thread that issued it.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   stall           global pipeline stall; blocks new fetch issue
//   start_valid/id  activate a thread context (IDs 5-7 ignored)
//   halt_valid/id   deactivate a thread context (IDs 5-7 ignored)
//   redirect_valid  overwrite PC of redirect_id with the branch target
//   sel_read        thread whose PC is driven to fetch (= current thread)
//   sel_write       thread whose PC is written this cycle
//   pc_en           PC repository write enable
//   pc_sel_target   next-PC mux select: 1 = redirect target, 0 = PC+4
//   fetch_valid_q   registered: instruction returned this cycle is valid
//   fetch_thread_q  registered: thread tag for the returned instruction
//   active_q        registered thread-active mask, bit i = thread i
//   idle            no thread is active
//
// Request semantics: start/halt/redirect are single-cycle valid strobes with
// no ready. A strobe is consumed on the rising edge where its valid is high;
// holding valid for N cycles means N requests. There is no backpressure.
// ---------------------------------------------------------------------------
module thread_scheduler #(
  parameter int NUM_THREADS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       start_valid,
  input  logic [2:0] start_id,
  input  logic       halt_valid,
  input  logic [2:0] halt_id,
  input  logic       redirect_valid,
  input  logic [2:0] redirect_id,
  output logic [2:0] sel_read,
  output logic [2:0] sel_write,
  output logic       pc_en,
  output logic       pc_sel_target,
  output logic       fetch_valid_q,
  output logic [2:0] fetch_thread_q,
  output logic [4:0] active_q,
  output logic       idle
);

  // Current thread; the scheduler's only sequencing state, visible on sel_read.
  logic [2:0] cur_q, cur_d;
  logic [4:0] active_d;
  logic       fetch_valid_d;
  logic [2:0] fetch_thread_d;

  logic       cur_active;
  logic       issue;
  logic       advance;

  // Decoded one-hot for a thread ID. IDs outside 0-4 decode to zero, which
  // makes out-of-range start/halt requests fall through as no-ops.
  function automatic logic [4:0] id_onehot(input logic [2:0] id);
    logic [4:0] oh;
    case (id)
      3'd0:    oh = 5'b00001;
      3'd1:    oh = 5'b00010;
      3'd2:    oh = 5'b00100;
      3'd3:    oh = 5'b01000;
      3'd4:    oh = 5'b10000;
      default: oh = 5'b00000;
    endcase
    return oh;
  endfunction

  // -------------------------------------------------------------------------
  // Active mask update: set on start first, then clear on halt, so a halt of
  // the same ID in the same cycle wins.
  // -------------------------------------------------------------------------
  always_comb begin
    active_d = active_q;
    if (start_valid) begin
      active_d = active_d | id_onehot(start_id);
    end
    if (halt_valid) begin
      active_d = active_d & ~id_onehot(halt_id);
    end
  end

  // -------------------------------------------------------------------------
  // Issue decision. A redirect owns the PC write port this cycle, so the
  // current thread loses its slot but keeps its place in the rotation.
  // Issue looks at active_q (not active_d): a thread halted in the cycle it
  // is current still completes that issue.
  // -------------------------------------------------------------------------
  assign cur_active = |(active_q & id_onehot(cur_q));
  assign issue      = cur_active & ~stall & ~redirect_valid;
  assign advance    = ~stall & ~redirect_valid;

  // -------------------------------------------------------------------------
  // Round-robin pick: first active thread in active_d searching from cur+1
  // upward with wrap, ending at cur itself. Searching active_d (not active_q)
  // means a freshly started thread is eligible on the very next slot and a
  // freshly halted one is skipped. If no thread is active, cur holds.
  // -------------------------------------------------------------------------
  logic [3:0] cand;
  logic       found;

  always_comb begin
    cur_d = cur_q;
    cand  = '0;
    found = 1'b0;
    if (advance) begin
      for (int k = 1; k <= NUM_THREADS; k++) begin
        cand = {1'b0, cur_q} + 4'(k);
        if (cand >= 4'(NUM_THREADS)) begin
          cand = cand - 4'(NUM_THREADS);
        end
        if (!found && (|(active_d & id_onehot(cand[2:0])))) begin
          cur_d = cand[2:0];
          found = 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // PC repository control. Redirects are honoured even under stall because
  // they repair architectural state, not fetch bandwidth.
  // -------------------------------------------------------------------------
  always_comb begin
    sel_write     = cur_q;
    pc_en         = issue;
    pc_sel_target = 1'b0;
    if (reset) begin
      sel_write     = '0;
      pc_en         = 1'b0;
      pc_sel_target = 1'b0;
    end else if (redirect_valid) begin
      sel_write     = redirect_id;
      pc_en         = 1'b1;
      pc_sel_target = 1'b1;
    end
  end

  assign sel_read = cur_q;
  assign idle     = (active_q == 5'b00000);

  // Fetch return tag: the instruction read this cycle comes back next cycle.
  // Under stall the returned instruction is frozen, so its tag is held too.
  always_comb begin
    fetch_valid_d  = fetch_valid_q;
    fetch_thread_d = fetch_thread_q;
    if (!stall) begin
      fetch_valid_d  = issue;
      fetch_thread_d = cur_q;
    end
  end

  // -------------------------------------------------------------------------
  // State registers. Reset comes out with only thread 0 active and current,
  // so thread 0 issues in the first cycle after release.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q       <= 5'b00001;
      cur_q          <= '0;
      fetch_valid_q  <= 1'b0;
      fetch_thread_q <= '0;
    end else begin
      active_q       <= active_d;
      cur_q          <= cur_d;
      fetch_valid_q  <= fetch_valid_d;
      fetch_thread_q <= fetch_thread_d;
    end
  end

endmodule

// File: tb/tb_thread_scheduler.sv
// ---------------------------------------------------------------------------
// tb_thread_scheduler
//
// Directed scenarios with hand-derived expected values, followed by a
// randomized run checked against a behavioural model of the scheduling rules
// (thread set as a bit array, rotation by modulo arithmetic).
// Inputs change on the falling edge; outputs are sampled mid-low-phase.
// ---------------------------------------------------------------------------
module tb_thread_scheduler;

  logic       clk;
  logic       reset;
  logic       stall;
  logic       start_valid;
  logic [2:0] start_id;
  logic       halt_valid;
  logic [2:0] halt_id;
  logic       redirect_valid;
  logic [2:0] redirect_id;
  logic [2:0] sel_read;
  logic [2:0] sel_write;
  logic       pc_en;
  logic       pc_sel_target;
  logic       fetch_valid_q;
  logic [2:0] fetch_thread_q;
  logic [4:0] active_q;
  logic       idle;

  int checks = 0;
  int errors = 0;

  thread_scheduler #(.NUM_THREADS(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .start_valid    (start_valid),
    .start_id       (start_id),
    .halt_valid     (halt_valid),
    .halt_id        (halt_id),
    .redirect_valid (redirect_valid),
    .redirect_id    (redirect_id),
    .sel_read       (sel_read),
    .sel_write      (sel_write),
    .pc_en          (pc_en),
    .pc_sel_target  (pc_sel_target),
    .fetch_valid_q  (fetch_valid_q),
    .fetch_thread_q (fetch_thread_q),
    .active_q       (active_q),
    .idle           (idle)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    stall          = 1'b0;
    start_valid    = 1'b0;
    start_id       = '0;
    halt_valid     = 1'b0;
    halt_id        = '0;
    redirect_valid = 1'b0;
    redirect_id    = '0;
  endtask

  // Advance one clock; returns on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Bring active mask to 5'b11111 without moving the current thread (0).
  task automatic start_all_stalled();
    for (int t = 1; t <= 4; t++) begin
      stall       = 1'b1;
      start_valid = 1'b1;
      start_id    = 3'(t);
      tick();
    end
    clear_inputs();
  endtask

  // ---------------- reference model ----------------
  bit m_act [5];
  int m_cur;
  bit m_fv;
  int m_ft;

  logic       exp_pc_en;
  logic       exp_sel_target;
  logic [2:0] exp_sel_write;

  function automatic logic [4:0] model_mask();
    logic [4:0] v;
    for (int i = 0; i < 5; i++) v[i] = m_act[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_act[i] = (i == 0);
    m_cur = 0;
    m_fv  = 1'b0;
    m_ft  = 0;
  endtask

  task automatic model_outputs();
    bit may_issue;
    may_issue = m_act[m_cur] && !stall && !redirect_valid;
    if (reset) begin
      exp_pc_en      = 1'b0;
      exp_sel_target = 1'b0;
      exp_sel_write  = 3'(m_cur);
    end else if (redirect_valid) begin
      exp_pc_en      = 1'b1;
      exp_sel_target = 1'b1;
      exp_sel_write  = redirect_id;
    end else begin
      exp_pc_en      = may_issue;
      exp_sel_target = 1'b0;
      exp_sel_write  = 3'(m_cur);
    end
  endtask

  task automatic model_tick();
    bit nxt [5];
    bit may_issue;
    bit done;
    int t;
    if (reset) begin
      model_reset();
      return;
    end
    nxt = m_act;
    if (start_valid && start_id < 5) nxt[start_id] = 1'b1;
    if (halt_valid && halt_id < 5) nxt[halt_id] = 1'b0;
    may_issue = m_act[m_cur] && !stall && !redirect_valid;
    if (!stall) begin
      m_fv = may_issue;
      m_ft = m_cur;
    end
    if (!stall && !redirect_valid) begin
      done = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        t = (m_cur + k) % 5;
        if (!done && nxt[t]) begin
          m_cur = t;
          done  = 1'b1;
        end
      end
    end
    m_act = nxt;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // Reset applied during a redirect and a start: must win over both.
    clear_inputs();
    reset          = 1'b1;
    start_valid    = 1'b1;
    start_id       = 3'd2;
    redirect_valid = 1'b1;
    redirect_id    = 3'd3;
    #1;
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL reset_pc_en got %0b exp 0", pc_en); end
    checks++; if (pc_sel_target !== 1'b0) begin errors++; $display("FAIL reset_sel_target got %0b exp 0", pc_sel_target); end
    tick();
    checks++; if (active_q !== 5'b00001) begin errors++; $display("FAIL reset_active got %b exp 00001", active_q); end
    checks++; if (fetch_valid_q !== 1'b0) begin errors++; $display("FAIL reset_fvalid got %0b exp 0", fetch_valid_q); end
    checks++; if (fetch_thread_q !== 3'd0) begin errors++; $display("FAIL reset_fthread got %0d exp 0", fetch_thread_q); end
    checks++; if (sel_read !== 3'd0) begin errors++; $display("FAIL reset_sel_read got %0d exp 0", sel_read); end
    checks++; if (sel_write !== 3'd0) begin errors++; $display("FAIL reset_sel_write got %0d exp 0", sel_write); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL reset_idle got %0b exp 0", idle); end
    clear_inputs();
    reset = 1'b0;
    #1;
    checks++; if (pc_en !== 1'b1 || sel_read !== 3'd0) begin
      errors++; $display("FAIL reset_first_issue pc_en %0b sel_read %0d exp 1 0", pc_en, sel_read);
    end
    tick();
    checks++; if (fetch_valid_q !== 1'b1 || fetch_thread_q !== 3'd0) begin
      errors++; $display("FAIL reset_first_tag valid %0b thread %0d exp 1 0", fetch_valid_q, fetch_thread_q);
    end
  endtask

  task automatic test_round_robin();
    int exp_sel;
    do_reset();
    for (int t = 1; t <= 4; t++) begin
      start_valid = 1'b1;
      start_id    = 3'(t);
      #1;
      checks++; if (sel_read !== 3'(t - 1) || pc_en !== 1'b1) begin
        errors++; $display("FAIL rr_ramp_issue step %0d sel_read %0d pc_en %0b exp %0d 1", t, sel_read, pc_en, t - 1);
      end
      tick();
      checks++; if (fetch_valid_q !== 1'b1 || fetch_thread_q !== 3'(t - 1)) begin
        errors++; $display("FAIL rr_ramp_tag step %0d valid %0b thread %0d exp 1 %0d", t, fetch_valid_q, fetch_thread_q, t - 1);
      end
    end
    clear_inputs();
    checks++; if (active_q !== 5'b11111) begin errors++; $display("FAIL rr_active got %b exp 11111", active_q); end
    for (int j = 0; j < 7; j++) begin
      exp_sel = (4 + j) % 5;
      #1;
      checks++; if (sel_read !== 3'(exp_sel) || pc_en !== 1'b1 || pc_sel_target !== 1'b0) begin
        errors++; $display("FAIL rr_issue slot %0d sel_read %0d pc_en %0b tgt %0b exp %0d 1 0", j, sel_read, pc_en, pc_sel_target, exp_sel);
      end
      tick();
      checks++; if (fetch_thread_q !== 3'(exp_sel) || fetch_valid_q !== 1'b1) begin
        errors++; $display("FAIL rr_tag slot %0d thread %0d valid %0b exp %0d 1", j, fetch_thread_q, fetch_valid_q, exp_sel);
      end
    end
  endtask

  task automatic test_redirect();
    int exp_seq [3] = '{2, 4, 0};
    do_reset();
    stall = 1'b1; start_valid = 1'b1; start_id = 3'd2; tick();
    stall = 1'b1; start_valid = 1'b1; start_id = 3'd4; tick();
    clear_inputs(); tick();          // thread 0 issues, rotation moves to 2
    checks++; if (active_q !== 5'b10101 || sel_read !== 3'd2) begin
      errors++; $display("FAIL redir_setup active %b sel_read %0d exp 10101 2", active_q, sel_read);
    end
    redirect_valid = 1'b1;
    redirect_id    = 3'd4;
    #1;
    checks++; if (sel_write !== 3'd4 || pc_sel_target !== 1'b1 || pc_en !== 1'b1) begin
      errors++; $display("FAIL redir_write sel_write %0d tgt %0b pc_en %0b exp 4 1 1", sel_write, pc_sel_target, pc_en);
    end
    tick();
    clear_inputs();
    checks++; if (fetch_valid_q !== 1'b0 || sel_read !== 3'd2) begin
      errors++; $display("FAIL redir_hold fvalid %0b sel_read %0d exp 0 2", fetch_valid_q, sel_read);
    end
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++; if (sel_read !== 3'(exp_seq[j]) || pc_en !== 1'b1 || sel_write !== 3'(exp_seq[j])) begin
        errors++; $display("FAIL redir_resume slot %0d sel_read %0d sel_write %0d pc_en %0b exp %0d", j, sel_read, sel_write, pc_en, exp_seq[j]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    start_all_stalled();
    tick();                          // thread 0 issues, current becomes 1
    for (int j = 0; j < 3; j++) begin
      stall = 1'b1;
      redirect_valid = (j == 1);
      redirect_id    = 3'd3;
      #1;
      if (j == 1) begin
        checks++; if (pc_en !== 1'b1 || sel_write !== 3'd3 || pc_sel_target !== 1'b1) begin
          errors++; $display("FAIL stall_redirect pc_en %0b sel_write %0d tgt %0b exp 1 3 1", pc_en, sel_write, pc_sel_target);
        end
      end else begin
        checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL stall_pc_en cycle %0d got %0b exp 0", j, pc_en); end
      end
      checks++; if (sel_read !== 3'd1 || fetch_valid_q !== 1'b1 || fetch_thread_q !== 3'd0) begin
        errors++; $display("FAIL stall_hold cycle %0d sel_read %0d valid %0b thread %0d exp 1 1 0", j, sel_read, fetch_valid_q, fetch_thread_q);
      end
      tick();
    end
    clear_inputs();
    #1;
    checks++; if (sel_read !== 3'd1 || pc_en !== 1'b1) begin
      errors++; $display("FAIL stall_release sel_read %0d pc_en %0b exp 1 1", sel_read, pc_en);
    end
    tick();
    checks++; if (fetch_thread_q !== 3'd1 || fetch_valid_q !== 1'b1 || sel_read !== 3'd2) begin
      errors++; $display("FAIL stall_after thread %0d valid %0b sel_read %0d exp 1 1 2", fetch_thread_q, fetch_valid_q, sel_read);
    end
  endtask

  task automatic test_halt();
    do_reset();
    stall = 1'b1; start_valid = 1'b1; start_id = 3'd1; tick();
    clear_inputs();
    halt_valid = 1'b1;
    halt_id    = 3'd0;
    #1;
    checks++; if (pc_en !== 1'b1 || sel_read !== 3'd0) begin
      errors++; $display("FAIL halt_self_issue pc_en %0b sel_read %0d exp 1 0", pc_en, sel_read);
    end
    tick();
    clear_inputs();
    checks++; if (active_q !== 5'b00010 || fetch_valid_q !== 1'b1 || fetch_thread_q !== 3'd0) begin
      errors++; $display("FAIL halt_self_after active %b valid %0b thread %0d exp 00010 1 0", active_q, fetch_valid_q, fetch_thread_q);
    end
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++; if (sel_read !== 3'd1 || pc_en !== 1'b1) begin
        errors++; $display("FAIL halt_other slot %0d sel_read %0d pc_en %0b exp 1 1", j, sel_read, pc_en);
      end
      tick();
    end
    halt_valid = 1'b1;
    halt_id    = 3'd1;
    #1;
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL halt_last_issue pc_en %0b exp 1", pc_en); end
    tick();
    clear_inputs();
    checks++; if (active_q !== 5'b00000 || idle !== 1'b1) begin
      errors++; $display("FAIL halt_idle active %b idle %0b exp 00000 1", active_q, idle);
    end
    for (int j = 0; j < 2; j++) begin
      #1;
      checks++; if (pc_en !== 1'b0 || idle !== 1'b1) begin
        errors++; $display("FAIL halt_idle_pc_en slot %0d pc_en %0b idle %0b exp 0 1", j, pc_en, idle);
      end
      tick();
      checks++; if (fetch_valid_q !== 1'b0) begin errors++; $display("FAIL halt_idle_fvalid slot %0d got %0b exp 0", j, fetch_valid_q); end
    end
  endtask

  task automatic test_start_halt_same();
    do_reset();
    start_valid = 1'b1; start_id = 3'd3; halt_valid = 1'b1; halt_id = 3'd3;
    tick();
    clear_inputs();
    checks++; if (active_q !== 5'b00001) begin errors++; $display("FAIL same_id_halt_wins got %b exp 00001", active_q); end
    start_valid = 1'b1; start_id = 3'd6;
    tick();
    clear_inputs();
    checks++; if (active_q !== 5'b00001) begin errors++; $display("FAIL start_id6_ignored got %b exp 00001", active_q); end
    halt_valid = 1'b1; halt_id = 3'd7;
    tick();
    clear_inputs();
    checks++; if (active_q !== 5'b00001) begin errors++; $display("FAIL halt_id7_ignored got %b exp 00001", active_q); end
    start_valid = 1'b1; start_id = 3'd3; halt_valid = 1'b1; halt_id = 3'd5;
    tick();
    clear_inputs();
    checks++; if (active_q !== 5'b01001) begin errors++; $display("FAIL start3_halt5 got %b exp 01001", active_q); end
  endtask

  task automatic test_reset_during_redirect();
    do_reset();
    start_all_stalled();
    tick();
    tick();
    checks++; if (active_q !== 5'b11111 || sel_read !== 3'd2) begin
      errors++; $display("FAIL rst_redir_setup active %b sel_read %0d exp 11111 2", active_q, sel_read);
    end
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_id    = 3'd2;
    #1;
    checks++; if (pc_en !== 1'b0 || pc_sel_target !== 1'b0) begin
      errors++; $display("FAIL rst_redir_ctrl pc_en %0b tgt %0b exp 0 0", pc_en, pc_sel_target);
    end
    tick();
    checks++; if (active_q !== 5'b00001 || sel_read !== 3'd0 || fetch_valid_q !== 1'b0) begin
      errors++; $display("FAIL rst_redir_state active %b sel_read %0d valid %0b exp 00001 0 0", active_q, sel_read, fetch_valid_q);
    end
    reset = 1'b0;
    clear_inputs();
    #1;
    checks++; if (pc_en !== 1'b1 || sel_read !== 3'd0 || sel_write !== 3'd0) begin
      errors++; $display("FAIL rst_redir_first pc_en %0b sel_read %0d sel_write %0d exp 1 0 0", pc_en, sel_read, sel_write);
    end
    tick();
    checks++; if (fetch_valid_q !== 1'b1 || fetch_thread_q !== 3'd0) begin
      errors++; $display("FAIL rst_redir_tag valid %0b thread %0d exp 1 0", fetch_valid_q, fetch_thread_q);
    end
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      reset          = ($urandom_range(0, 63) == 0);
      stall          = ($urandom_range(0, 3) == 0);
      start_valid    = ($urandom_range(0, 2) == 0);
      start_id       = 3'($urandom_range(0, 7));
      halt_valid     = ($urandom_range(0, 4) == 0);
      halt_id        = 3'($urandom_range(0, 7));
      redirect_valid = ($urandom_range(0, 5) == 0);
      redirect_id    = 3'($urandom_range(0, 4));
      #1;
      model_outputs();
      checks++; if (pc_en !== exp_pc_en || pc_sel_target !== exp_sel_target) begin
        errors++; $display("FAIL rand_ctrl cycle %0d pc_en %0b tgt %0b exp %0b %0b", n, pc_en, pc_sel_target, exp_pc_en, exp_sel_target);
      end
      checks++; if (sel_read !== 3'(m_cur) || idle !== (model_mask() == 5'b0)) begin
        errors++; $display("FAIL rand_sel_read cycle %0d sel_read %0d idle %0b exp %0d", n, sel_read, idle, m_cur);
      end
      if (!reset) begin
        checks++; if (sel_write !== exp_sel_write) begin
          errors++; $display("FAIL rand_sel_write cycle %0d got %0d exp %0d", n, sel_write, exp_sel_write);
        end
      end
      model_tick();
      tick();
      checks++; if (active_q !== model_mask()) begin
        errors++; $display("FAIL rand_active cycle %0d got %b exp %b", n, active_q, model_mask());
      end
      checks++; if (fetch_valid_q !== m_fv || fetch_thread_q !== 3'(m_ft)) begin
        errors++; $display("FAIL rand_fetch cycle %0d valid %0b thread %0d exp %0b %0d", n, fetch_valid_q, fetch_thread_q, m_fv, m_ft);
      end
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_redirect();
    test_stall();
    test_halt();
    test_start_halt_same();
    test_reset_during_redirect();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
